// File: rtl/uart_loopback.sv
`timescale 1ns/1ps
// uart_loopback: 8N1 receiver -> byte buffer -> 8N1 transmitter echo path, one clock domain.
// Build option LOOPBACK_FIFO_EN selects a FIFO_DEPTH-byte FIFO; otherwise a single holding register.
module uart_loopback #(
   parameter int CLOCK_FREQUENCY = 50_000_000,
   parameter int BAUD_RATE       = 115200,
   parameter int FIFO_DEPTH      = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic tx
);
   localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   if (CLKS_PER_BIT < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("uart_loopback: need CLKS_PER_BIT >= 2 and power-of-two FIFO_DEPTH >= 2");
   end

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   logic             rx_meta_q, rx_sync_q;
   rx_state_t        rx_state_q;
   logic [CNT_W-1:0] rx_cnt_q;
   logic [2:0]       rx_idx_q;
   logic [7:0]       rx_shift_q;
   logic             rx_armed_q, rx_vld_q;

   tx_state_t        tx_state_q;
   logic [CNT_W-1:0] tx_cnt_q;
   logic [2:0]       tx_idx_q;
   logic [7:0]       tx_data_q;
   logic             tx_q;

   logic             buf_empty, tx_pop;
   logic [7:0]       buf_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // After any frame, a start is only accepted once the line has been seen high again.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_idx_q   <= '0;
         rx_shift_q <= '0;
         rx_armed_q <= 1'b0;
         rx_vld_q   <= 1'b0;
      end else begin
         rx_vld_q <= 1'b0;
         case (rx_state_q)
            RX_IDLE: begin
               rx_cnt_q <= '0;
               rx_idx_q <= '0;
               if (!rx_armed_q)     rx_armed_q <= rx_sync_q;
               else if (!rx_sync_q) rx_state_q <= RX_START;
            end
            RX_START: begin
               if (rx_cnt_q == HALF_LAST) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
               end else rx_cnt_q <= rx_cnt_q + CNT_W'(1);
            end
            RX_DATA: begin
               if (rx_cnt_q == BIT_LAST) begin
                  rx_cnt_q   <= '0;
                  rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                  rx_idx_q   <= rx_idx_q + 3'd1;
                  if (rx_idx_q == 3'd7) rx_state_q <= RX_STOP;
               end else rx_cnt_q <= rx_cnt_q + CNT_W'(1);
            end
            RX_STOP: begin
               if (rx_cnt_q == BIT_LAST) begin
                  rx_cnt_q   <= '0;
                  rx_vld_q   <= rx_sync_q;
                  rx_armed_q <= 1'b0;
                  rx_state_q <= RX_IDLE;
               end else rx_cnt_q <= rx_cnt_q + CNT_W'(1);
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   // Pop on the last stop-bit clock too, so queued frames go out back-to-back.
   assign tx_pop = !buf_empty &&
                   (tx_state_q == TX_IDLE || (tx_state_q == TX_STOP && tx_cnt_q == BIT_LAST));

`ifdef LOOPBACK_FIFO_EN
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push_ok;

   always_comb begin
      push_ok  = rx_vld_q && (count_q != FULL_CNT);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
         count_d  = count_d + (PTR_W + 1)'(1);
      end
      if (tx_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d  = count_d - (PTR_W + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_ok) mem_q[wr_ptr_q] <= rx_shift_q;
      end
   end

   assign buf_empty = (count_q == '0);
   assign buf_data  = mem_q[rd_ptr_q];
`else
   logic [7:0] hold_q, hold_d;
   logic       hold_vld_q, hold_vld_d;

   always_comb begin
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      if (tx_pop) hold_vld_d = 1'b0;
      if (rx_vld_q && !hold_vld_q) begin
         hold_d     = rx_shift_q;
         hold_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
      end
   end

   assign buf_empty = !hold_vld_q;
   assign buf_data  = hold_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_data_q  <= '0;
         tx_q       <= 1'b1;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               tx_cnt_q <= '0;
               if (tx_pop) begin
                  tx_q       <= 1'b0;
                  tx_data_q  <= buf_data;
                  tx_state_q <= TX_START;
               end
            end
            TX_START: begin
               if (tx_cnt_q == BIT_LAST) begin
                  tx_cnt_q   <= '0;
                  tx_idx_q   <= '0;
                  tx_q       <= tx_data_q[0];
                  tx_data_q  <= {1'b0, tx_data_q[7:1]};
                  tx_state_q <= TX_DATA;
               end else tx_cnt_q <= tx_cnt_q + CNT_W'(1);
            end
            TX_DATA: begin
               if (tx_cnt_q == BIT_LAST) begin
                  tx_cnt_q <= '0;
                  if (tx_idx_q == 3'd7) begin
                     tx_q       <= 1'b1;
                     tx_state_q <= TX_STOP;
                  end else begin
                     tx_q      <= tx_data_q[0];
                     tx_data_q <= {1'b0, tx_data_q[7:1]};
                     tx_idx_q  <= tx_idx_q + 3'd1;
                  end
               end else tx_cnt_q <= tx_cnt_q + CNT_W'(1);
            end
            TX_STOP: begin
               if (tx_cnt_q == BIT_LAST) begin
                  tx_cnt_q <= '0;
                  if (tx_pop) begin
                     tx_q       <= 1'b0;
                     tx_data_q  <= buf_data;
                     tx_state_q <= TX_START;
                  end else tx_state_q <= TX_IDLE;
               end else tx_cnt_q <= tx_cnt_q + CNT_W'(1);
            end
            default: tx_state_q <= TX_IDLE;
         endcase
      end
   end

   assign tx = tx_q;

endmodule

// File: tb/tb_uart_loopback.sv
`timescale 1ns/1ps
// tb_uart_loopback: directed rx stimulus with an expected-byte queue checked by a tx frame monitor.
module tb_uart_loopback;
   localparam int CLK_FREQ = 50_000_000;
   localparam int BAUD     = 1_500_000;
   localparam int CPB      = CLK_FREQ / BAUD;   // 33, exercises the floor division
   localparam int HALF     = CPB / 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;
   logic tx;

   int   tests = 0;
   int   fails = 0;
   logic [7:0] exp_q[$];
   time  start_log[$];
   bit   mon_busy = 1'b0;
   time  stop_t;

   uart_loopback #(.CLOCK_FREQUENCY(CLK_FREQ), .BAUD_RATE(BAUD), .FIFO_DEPTH(16)) dut (
      .clk(clk), .rst(rst), .rx(rx), .tx(tx)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Caller must be sitting on a negedge; returns on a negedge with rx idle.
   task automatic send_byte(input logic [7:0] b, input logic stop, input bit expect_echo);
      if (expect_echo) exp_q.push_back(b);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      stop_t = $time;
      rx = stop;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic wait_idle(input int max_cyc, input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || mon_busy) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(exp_q.size() == 0 && !mon_busy), 32'd1);
   endtask

   // tx frame monitor: every bit must hold its value for exactly CPB clocks.
   initial begin : monitor
      logic [9:0] fr;
      logic [7:0] got;
      bit ok, aborted, have;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0 || tx !== 1'b0) continue;
         mon_busy = 1'b1;
         start_log.push_back($time);
         have = (exp_q.size() != 0);
         chk("frame_expected", 32'(have), 32'd1);
         if (have) fr = {1'b1, exp_q.pop_front(), 1'b0};
         else      fr = '1;
         aborted = 1'b0;
         got = '0;
         for (int b = 0; b < 10 && !aborted; b++) begin
            ok = 1'b1;
            for (int k = 0; k < CPB && !aborted; k++) begin
               if (b != 0 || k != 0) @(negedge clk);
               if (rst) aborted = 1'b1;
               else begin
                  if (tx !== fr[b]) ok = 1'b0;
                  if (k == HALF && b >= 1 && b <= 8) got[b-1] = tx;
               end
            end
            if (!aborted && have) chk($sformatf("tx_bit%0d", b), 32'(ok), 32'd1);
         end
         if (!aborted && have) chk("echo_byte", 32'(got), 32'(fr[8:1]));
         mon_busy = 1'b0;
      end
   end

   initial begin : watchdog
      #4ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [7:0] seq [10];
      logic [7:0] b;
      bit ok;
      int lat;
      int n;
      seq = '{8'h54, 8'h2C, 8'h14, 8'h0E, 8'h53, 8'h49, 8'hC5, 8'h00, 8'hF3, 8'hBD};

      repeat (10) @(negedge clk);
      rst = 1'b0;
      chk("reset_tx", 32'(tx), 32'd1);
      ok = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (tx !== 1'b1) ok = 1'b0;
      end
      chk("idle_tx_high", 32'(ok), 32'd1);
      chk("idle_no_frames", 32'(start_log.size()), 32'd0);

      send_byte(8'h54, 1'b1, 1'b1);
      wait_idle(20 * CPB, "drain_54");
      lat = int'((start_log[start_log.size()-1] - stop_t) / 20);
      chk("start_latency", 32'(lat >= HALF && lat <= HALF + 6), 32'd1);

      for (int i = 0; i < 47; i++) begin
         b = (i < 10) ? seq[i] : 8'($urandom_range(0, 255));
         send_byte(b, 1'b1, 1'b1);
         repeat (500) @(negedge clk);
      end
      wait_idle(20 * CPB, "drain_seq47");

      send_byte(8'h00, 1'b1, 1'b1);
      send_byte(8'hFF, 1'b1, 1'b1);
      wait_idle(30 * CPB, "drain_b2b");
      n = start_log.size();
      chk("b2b_spacing", 32'((start_log[n-1] - start_log[n-2]) / 20), 32'(10 * CPB));

      n = start_log.size();
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      send_byte(8'h6B, 1'b0, 1'b0);
      repeat (15 * CPB) @(negedge clk);
      chk("reject_frames", 32'(start_log.size() - n), 32'd0);
      send_byte(8'hA5, 1'b1, 1'b1);
      wait_idle(20 * CPB, "drain_a5");

      send_byte(8'hC5, 1'b1, 1'b1);
      n = 0;
      while (!mon_busy && n < 20 * CPB) begin
         @(negedge clk);
         n++;
      end
      chk("c5_echo_started", 32'(mon_busy), 32'd1);
      repeat (5) @(negedge clk);
      chk("tx_low_before_rst", 32'(tx), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("tx_after_rst", 32'(tx), 32'd1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n = start_log.size();
      repeat (15 * CPB) @(negedge clk);
      chk("no_resume_after_rst", 32'(start_log.size() - n), 32'd0);
      send_byte(8'h3C, 1'b1, 1'b1);
      wait_idle(20 * CPB, "drain_3c");
      repeat (2 * CPB) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
